seq_controller_mc: RTL and testbench
====================================

Name: seq_controller_mc

Overview:
- Multi-cycle successor to the accumulator-CPU controller: drives IR/PC/Acc/Reg load and select strobes from a 4-bit opcode and the Z/C flags.
- Adds a memory-ready fetch handshake with a parametrised timeout.
- Adds iterative multi-bit shifts, PC increment on not-taken branches, sticky illegal/fault flags and a resumable HALT state.
- Sits between the instruction register/flag register and the datapath in the micro top level.

Parameters:
- SHAMT_W, 3, width of shift-amount field; shifts repeat up to 2^SHAMT_W-1 times.
- TIMEOUT, 15, max FETCH cycles waiting for mem_ready before fault; 0 disables the timeout.
- TO_W, 4, width of timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge.
- CLB  in  1  reset, synchronous, active-high.
- Opcode  in  4  current IR opcode, valid from the cycle after LoadIR.
- Shamt  in  SHAMT_W  IR shift-amount field.
- Z  in  1  zero flag.
- C  in  1  carry flag.
- mem_ready  in  1  instruction memory data valid.
- resume  in  1  leave HALT.
- LoadIR  out  1  load instruction register.
- IncPC  out  1  PC <= PC+1.
- SelPC  out  1  1 = jump target from register, 0 = immediate.
- LoadPC  out  1  load PC with jump target.
- LoadReg  out  1  write Acc into rd.
- LoadAcc  out  1  write Acc.
- SelAcc  out  2  Acc source: 00 ALU, 01 rs, 10 immediate.
- SelALU  out  4  ALU op / shift control.
- halted  out  1  in HALT.
- illegal  out  1  sticky; reserved opcode executed.
- fault  out  1  sticky; fetch timeout.

Behaviour:
- Outputs are combinational from state, Opcode, Z, C, shift counter and resume. The state, counters and sticky flags are registered.
- Default output value in every state is 0 unless stated otherwise.
- CLB=1 at a rising edge: next state IDLE, counters cleared, illegal=0, fault=0.
- IDLE: all outputs 0; the next state is unconditionally FETCH.
- FETCH:
  - LoadIR = mem_ready.
  - If mem_ready=1, the next state is EXEC and the timeout counter clears.
  - Otherwise stay in FETCH and increment the timeout counter.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT with mem_ready still 0, set fault and go to HALT.
  - mem_ready=1 in the TIMEOUT-th cycle wins: normal fetch, no fault.
- EXEC lasts one cycle except for shifts; the next state is FETCH unless noted. Opcode decode:
  - 0 NOP: IncPC.
  - 1 ADD: SelALU=1000, SelAcc=00, LoadAcc, IncPC.
  - 2 SUB: SelALU=1100, LoadAcc, IncPC.
  - 3 NOR: SelALU=0100, LoadAcc, IncPC.
  - 4 MOV rs->Acc: SelAcc=01, LoadAcc, IncPC.
  - 5 MOV Acc->rd: LoadReg, IncPC.
  - 6 JZ reg: if Z then LoadPC, SelPC=1; else IncPC.
  - 7 JZ imm: if Z then LoadPC, SelPC=0; else IncPC.
  - 8 JC reg: if C then LoadPC, SelPC=1; else IncPC.
  - A JC imm: if C then LoadPC, SelPC=0; else IncPC.
  - B SHL and C SHR: see SHIFT.
  - D LDI: SelAcc=10, LoadAcc, IncPC.
  - 9, E reserved: behave as NOP and set illegal.
  - F HALT: no strobes; the next state is HALT.
- Flags Z and C are sampled in the EXEC cycle only.
- SHIFT (opcodes B and C):
  - Shamt=0: behaves as NOP (IncPC only, no LoadAcc).
  - Otherwise the shift counter loads Shamt.
  - Each cycle: LoadAcc=1 and SelALU=0001 (SHL) or 0011 (SHR); the counter decrements.
  - IncPC is asserted only in the cycle the counter equals 1; the next state is then FETCH.
  - A Shamt=k shift occupies exactly k cycles.
  - Opcode and Shamt must hold stable throughout; IR is not reloaded during SHIFT.
- HALT:
  - halted=1 and all strobes 0.
  - resume=1: IncPC=1 in that cycle, the next state is FETCH, and fault is not cleared.
  - Only CLB clears illegal and fault.
- Reset mid-SHIFT or mid-FETCH: strobes may still be combinationally active during the CLB=1 cycle. From the next cycle outputs reflect IDLE (all 0), and no partial shift or fetch completes.
- The datapath treats IncPC and LoadPC as mutually exclusive; they are never both 1 in any state.

Test Plan:
- Reset, then ADD (op=1) with mem_ready=1 held: cycle sequence IDLE, FETCH (LoadIR=1), EXEC with SelALU=1000, LoadAcc=1, IncPC=1, then FETCH again.
- JZ imm (op=7) with Z=0 -> IncPC=1, LoadPC=0. Same with Z=1 -> LoadPC=1, SelPC=0, IncPC=0. JC reg (op=8) with C=1 -> LoadPC=1, SelPC=1.
- SHR (op=C) with Shamt=5 -> exactly 5 consecutive cycles of LoadAcc=1, SelALU=0011, IncPC=1 only in the 5th. With Shamt=0 -> 1 cycle, IncPC=1, LoadAcc=0.
- mem_ready held 0 with TIMEOUT=15 -> 15 FETCH cycles, then fault=1, halted=1. Variant: mem_ready=1 in the 15th cycle -> EXEC, fault=0.
- HALT (op=F) -> halted=1. After 10 cycles assert resume -> IncPC=1 for one cycle, then FETCH. Reserved op=9 -> illegal=1, which remains 1 until CLB.
- Assert CLB in the 3rd cycle of a Shamt=7 shift -> next cycle all outputs 0, illegal=0 and fault=0, then FETCH.

Source files
------------

// File: rtl/seq_controller_mc.sv
// Multi-cycle accumulator-CPU controller: fetch handshake with timeout, iterative
// shifts, sticky illegal/fault flags and a resumable HALT state.
module seq_controller_mc #(
  parameter int SHAMT_W = 3,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic               clk,
  input  logic               CLB,
  input  logic [3:0]         Opcode,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Z,
  input  logic               C,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               LoadIR,
  output logic               IncPC,
  output logic               SelPC,
  output logic               LoadPC,
  output logic               LoadReg,
  output logic               LoadAcc,
  output logic [1:0]         SelAcc,
  output logic [3:0]         SelALU,
  output logic               halted,
  output logic               illegal,
  output logic               fault
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, SHIFT, HALT} state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t             stateReg, stateNext;
  logic [SHAMT_W-1:0] shCntReg, shCntNext;
  logic [TO_W-1:0]    toCntReg, toCntNext;
  logic               illegalReg, illegalNext;
  logic               faultReg, faultNext;
  logic               timeoutHit;

  assign illegal    = illegalReg;
  assign fault      = faultReg;
  assign timeoutHit = (TIMEOUT != 0) && (toCntReg == TO_LAST);

  always_ff @(posedge clk) begin
    if (CLB) begin
      stateReg   <= IDLE;
      shCntReg   <= '0;
      toCntReg   <= '0;
      illegalReg <= 1'b0;
      faultReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      shCntReg   <= shCntNext;
      toCntReg   <= toCntNext;
      illegalReg <= illegalNext;
      faultReg   <= faultNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    shCntNext   = shCntReg;
    toCntNext   = toCntReg;
    illegalNext = illegalReg;
    faultNext   = faultReg;
    LoadIR      = 1'b0;
    IncPC       = 1'b0;
    SelPC       = 1'b0;
    LoadPC      = 1'b0;
    LoadReg     = 1'b0;
    LoadAcc     = 1'b0;
    SelAcc      = 2'b00;
    SelALU      = 4'b0000;
    halted      = 1'b0;

    case (stateReg)
      IDLE: stateNext = FETCH;

      FETCH: begin
        LoadIR = mem_ready;
        if (mem_ready) begin
          stateNext = EXEC;
          toCntNext = '0;
        end else if (timeoutHit) begin
          faultNext = 1'b1;
          stateNext = HALT;
          toCntNext = '0;
        end else begin
          toCntNext = toCntReg + TO_W'(1);
        end
      end

      EXEC: begin
        stateNext = FETCH;
        case (Opcode)
          4'h1: begin SelALU = 4'b1000; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'h2: begin SelALU = 4'b1100; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'h3: begin SelALU = 4'b0100; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'h4: begin SelAcc = 2'b01; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'h5: begin LoadReg = 1'b1; IncPC = 1'b1; end
          4'h6, 4'h7: begin
            if (Z) begin LoadPC = 1'b1; SelPC = ~Opcode[0]; end
            else IncPC = 1'b1;
          end
          4'h8, 4'hA: begin
            if (C) begin LoadPC = 1'b1; SelPC = (Opcode == 4'h8); end
            else IncPC = 1'b1;
          end
          4'hB, 4'hC: begin
            // The EXEC cycle is the first shift step, so Shamt=k takes k cycles.
            if (Shamt == '0) begin
              IncPC = 1'b1;
            end else begin
              LoadAcc = 1'b1;
              SelALU  = (Opcode == 4'hC) ? 4'b0011 : 4'b0001;
              if (Shamt == SHAMT_W'(1)) begin
                IncPC = 1'b1;
              end else begin
                shCntNext = Shamt - SHAMT_W'(1);
                stateNext = SHIFT;
              end
            end
          end
          4'hD: begin SelAcc = 2'b10; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'h9, 4'hE: begin IncPC = 1'b1; illegalNext = 1'b1; end
          4'hF: stateNext = HALT;
          default: IncPC = 1'b1;
        endcase
      end

      SHIFT: begin
        LoadAcc = 1'b1;
        SelALU  = (Opcode == 4'hC) ? 4'b0011 : 4'b0001;
        if (shCntReg == SHAMT_W'(1)) begin
          IncPC     = 1'b1;
          shCntNext = '0;
          stateNext = FETCH;
        end else begin
          shCntNext = shCntReg - SHAMT_W'(1);
        end
      end

      HALT: begin
        halted = 1'b1;
        if (resume) begin
          IncPC     = 1'b1;
          stateNext = FETCH;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_controller_mc.sv
// Directed bench for seq_controller_mc: a decode table for single-cycle EXEC
// behaviour plus hand sequences for shifts, HALT/resume, fetch timeout and reset.
module tb_seq_controller_mc;
  localparam int SHAMT_W = 3;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;

  // Strobe field layout: {IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc[1:0], SelALU[3:0]}
  localparam logic [10:0] S_NONE  = 11'b0_0_0_0_0_00_0000;
  localparam logic [10:0] S_NOP   = 11'b1_0_0_0_0_00_0000;
  localparam logic [10:0] S_ADD   = 11'b1_0_0_0_1_00_1000;
  localparam logic [10:0] S_SUB   = 11'b1_0_0_0_1_00_1100;
  localparam logic [10:0] S_NOR   = 11'b1_0_0_0_1_00_0100;
  localparam logic [10:0] S_MOVA  = 11'b1_0_0_0_1_01_0000;
  localparam logic [10:0] S_MOVR  = 11'b1_0_0_1_0_00_0000;
  localparam logic [10:0] S_JREG  = 11'b0_1_1_0_0_00_0000;
  localparam logic [10:0] S_JIMM  = 11'b0_0_1_0_0_00_0000;
  localparam logic [10:0] S_SHL1  = 11'b1_0_0_0_1_00_0001;
  localparam logic [10:0] S_SHR1  = 11'b1_0_0_0_1_00_0011;
  localparam logic [10:0] S_SHLN  = 11'b0_0_0_0_1_00_0001;
  localparam logic [10:0] S_SHRN  = 11'b0_0_0_0_1_00_0011;
  localparam logic [10:0] S_LDI   = 11'b1_0_0_0_1_10_0000;

  logic               clk = 1'b0;
  logic               CLB = 1'b1;
  logic [3:0]         Opcode = 4'h0;
  logic [SHAMT_W-1:0] Shamt = '0;
  logic               Z = 1'b0, C = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic               LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]         SelAcc;
  logic [3:0]         SelALU;
  logic               halted, illegal, fault;
  logic [14:0]        outs;

  int nTests = 0;
  int nFail  = 0;
  logic expIll = 1'b0;
  logic expFault = 1'b0;

  always #5 clk = ~clk;

  seq_controller_mc #(.SHAMT_W(SHAMT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .CLB(CLB), .Opcode(Opcode), .Shamt(Shamt), .Z(Z), .C(C),
    .mem_ready(mem_ready), .resume(resume), .LoadIR(LoadIR), .IncPC(IncPC),
    .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc),
    .SelAcc(SelAcc), .SelALU(SelALU), .halted(halted), .illegal(illegal), .fault(fault)
  );

  assign outs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
                 halted, illegal, fault};

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  sh;
    logic        z;
    logic        c;
    logic [10:0] str;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] op, logic [2:0] sh, logic z, logic c, logic [10:0] str);
    vec_t v;
    v.op = op; v.sh = sh; v.z = z; v.c = c; v.str = str;
    return v;
  endfunction

  function automatic logic [14:0] full(logic ir, logic [10:0] str, logic h);
    return {ir, str, h, expIll, expFault};
  endfunction

  task automatic check(string name, logic [14:0] act, logic [14:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %b", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(4'h1, 3'd0, 1'b0, 1'b0, S_ADD));
    vecs.push_back(mk(4'h0, 3'd0, 1'b1, 1'b1, S_NOP));
    vecs.push_back(mk(4'h2, 3'd0, 1'b0, 1'b0, S_SUB));
    vecs.push_back(mk(4'h3, 3'd0, 1'b0, 1'b0, S_NOR));
    vecs.push_back(mk(4'h4, 3'd0, 1'b0, 1'b0, S_MOVA));
    vecs.push_back(mk(4'h5, 3'd0, 1'b0, 1'b0, S_MOVR));
    vecs.push_back(mk(4'h6, 3'd0, 1'b0, 1'b1, S_NOP));
    vecs.push_back(mk(4'h6, 3'd0, 1'b1, 1'b0, S_JREG));
    vecs.push_back(mk(4'h7, 3'd0, 1'b0, 1'b0, S_NOP));
    vecs.push_back(mk(4'h7, 3'd0, 1'b1, 1'b0, S_JIMM));
    vecs.push_back(mk(4'h7, 3'd0, 1'b0, 1'b1, S_NOP));
    vecs.push_back(mk(4'h8, 3'd0, 1'b0, 1'b1, S_JREG));
    vecs.push_back(mk(4'h8, 3'd0, 1'b1, 1'b0, S_NOP));
    vecs.push_back(mk(4'hA, 3'd0, 1'b0, 1'b1, S_JIMM));
    vecs.push_back(mk(4'hA, 3'd0, 1'b1, 1'b0, S_NOP));
    vecs.push_back(mk(4'hB, 3'd0, 1'b0, 1'b0, S_NOP));
    vecs.push_back(mk(4'hC, 3'd0, 1'b0, 1'b0, S_NOP));
    vecs.push_back(mk(4'hB, 3'd1, 1'b0, 1'b0, S_SHL1));
    vecs.push_back(mk(4'hC, 3'd1, 1'b0, 1'b0, S_SHR1));
    vecs.push_back(mk(4'hD, 3'd0, 1'b0, 1'b0, S_LDI));
    vecs.push_back(mk(4'h9, 3'd0, 1'b0, 1'b0, S_NOP));
    vecs.push_back(mk(4'hE, 3'd0, 1'b0, 1'b0, S_NOP));
    vecs.push_back(mk(4'h1, 3'd0, 1'b0, 1'b0, S_ADD));

    // Reset: IDLE with everything low, then FETCH.
    CLB = 1'b1;
    repeat (2) tick();
    check("reset_idle", outs, full(1'b0, S_NONE, 1'b0));
    CLB = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("first_fetch", outs, full(1'b1, S_NONE, 1'b0));

    // Decode table: each entry is one FETCH -> EXEC -> FETCH round trip.
    for (int i = 0; i < vecs.size(); i++) begin
      Opcode = vecs[i].op; Shamt = vecs[i].sh; Z = vecs[i].z; C = vecs[i].c;
      tick();
      check($sformatf("exec_v%0d_op%h", i, vecs[i].op), outs, full(1'b0, vecs[i].str, 1'b0));
      if (vecs[i].op == 4'h9 || vecs[i].op == 4'hE) expIll = 1'b1;
      tick();
      check($sformatf("fetch_v%0d", i), outs, full(1'b1, S_NONE, 1'b0));
    end
    Z = 1'b0; C = 1'b0;

    // SHR by 5: five LoadAcc cycles, IncPC only in the last.
    Opcode = 4'hC; Shamt = 3'd5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("shr5_c%0d", k), outs, full(1'b0, (k == 5) ? S_SHR1 : S_SHRN, 1'b0));
    end
    tick();
    check("shr5_refetch", outs, full(1'b1, S_NONE, 1'b0));

    // HALT for 10 cycles, then resume.
    Opcode = 4'hF; Shamt = 3'd0;
    tick();
    check("exec_halt", outs, full(1'b0, S_NONE, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("halted_c%0d", k), outs, full(1'b0, S_NONE, 1'b1));
    end
    resume = 1'b1;
    #1;
    check("resume_incpc", outs, full(1'b0, S_NOP, 1'b1));
    tick();
    resume = 1'b0;
    check("resume_fetch", outs, full(1'b1, S_NONE, 1'b0));

    // Reset in the 3rd cycle of a Shamt=7 SHL.
    Opcode = 4'hB; Shamt = 3'd7;
    tick();
    tick();
    tick();
    check("shl7_c3", outs, full(1'b0, S_SHLN, 1'b0));
    CLB = 1'b1;
    tick();
    expIll = 1'b0;
    check("reset_mid_shift", outs, full(1'b0, S_NONE, 1'b0));
    CLB = 1'b0;
    tick();
    check("fetch_after_reset", outs, full(1'b1, S_NONE, 1'b0));

    // Fetch timeout: 15 FETCH cycles without mem_ready -> HALT with fault.
    Opcode = 4'h0; Shamt = 3'd0;
    tick();
    check("exec_nop", outs, full(1'b0, S_NOP, 1'b0));
    mem_ready = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("wait_c%0d", k), outs, full(1'b0, S_NONE, 1'b0));
    end
    tick();
    expFault = 1'b1;
    check("timeout_halt", outs, full(1'b0, S_NONE, 1'b1));
    resume = 1'b1;
    #1;
    check("timeout_resume", outs, full(1'b0, S_NOP, 1'b1));
    tick();
    resume = 1'b0;
    check("fault_sticky", outs, full(1'b0, S_NONE, 1'b0));

    // Reset clears fault; mem_ready in the 15th cycle wins over the timeout.
    CLB = 1'b1;
    tick();
    expFault = 1'b0;
    check("reset_clears_fault", outs, full(1'b0, S_NONE, 1'b0));
    CLB = 1'b0;
    tick();
    check("late_c1", outs, full(1'b0, S_NONE, 1'b0));
    for (int k = 2; k <= 14; k++) tick();
    check("late_c14", outs, full(1'b0, S_NONE, 1'b0));
    tick();
    mem_ready = 1'b1;
    #1;
    check("late_c15_ready", outs, full(1'b1, S_NONE, 1'b0));
    tick();
    check("late_exec_no_fault", outs, full(1'b0, S_NOP, 1'b0));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
